// File: rtl/div_alu_seq_if.sv
// Request/response bundle for the sequential divider: operands and start in,
// status and results out. The ALU side stays as plain ports on the divider.
interface div_alu_seq_if;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        div_zero;

  modport master (
    output start, sign, dividend, divisor,
    input  busy, done, q, r, div_zero
  );

  modport slave (
    input  start, sign, dividend, divisor,
    output busy, done, q, r, div_zero
  );
endinterface

// File: rtl/div_alu_seq.sv
// Restoring DIV/DIVU controller sequencing every subtraction through the shared ALU (subu).
// Optional macro DIV_ZERO_CHK_EN: a zero divisor short-circuits to DONE and flags div_zero.
module div_alu_seq (
  input  logic               clk,
  input  logic               rst_n,
  div_alu_seq_if.slave       bus,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic [3:0]         alu_aluc,
  input  logic [31:0]        alu_r,
  input  logic               alu_carry
);
  localparam logic [3:0] ALUC_SUBU = 4'b0001;
  localparam int         ITERS     = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ITER,
    S_FIXQ,
    S_FIXR,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] quo, rem, ds;
  logic [4:0]  cnt;
  logic        qneg, rneg;
  logic        zskip;
  logic        busy_q, done_q, div_zero_q;
  logic [31:0] q_q, r_q;

  logic        accept;
  logic        take;
  logic        last_iter;
  logic        zero_div;
  logic        dv_neg, ds_neg;
  logic [31:0] dv_abs, ds_abs;
  logic [31:0] shifted;

  assign accept    = bus.start && (state == S_IDLE || state == S_DONE);
  assign shifted   = {rem[30:0], quo[31]};
  // rem[31] set means the true shifted value is >= 2^32, which always exceeds ds.
  assign take      = rem[31] | ~alu_carry;
  assign last_iter = (cnt == 5'(ITERS - 1));

  assign dv_neg = bus.sign & bus.dividend[31];
  assign ds_neg = bus.sign & bus.divisor[31];
  assign dv_abs = dv_neg ? (~bus.dividend + 32'd1) : bus.dividend;
  assign ds_abs = ds_neg ? (~bus.divisor + 32'd1) : bus.divisor;

`ifdef DIV_ZERO_CHK_EN
  assign zero_div = (bus.divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  assign alu_aluc     = ALUC_SUBU;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.q        = q_q;
  assign bus.r        = r_q;
  assign bus.div_zero = div_zero_q;

  // Next state and ALU operand decode; sign fix-ups are 0 - x through the ALU.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt = state;
    alu_a     = '0;
    alu_b     = '0;
    case (state)
      S_IDLE: if (accept) state_nxt = S_ITER;
      S_ITER: begin
        alu_a = shifted;
        alu_b = ds;
        if (zskip)          state_nxt = S_DONE;
        else if (last_iter) state_nxt = S_FIXQ;
      end
      S_FIXQ: begin
        alu_b     = quo;
        state_nxt = S_FIXR;
      end
      S_FIXR: begin
        alu_b     = rem;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = accept ? S_ITER : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      quo        <= '0;
      rem        <= '0;
      ds         <= '0;
      cnt        <= '0;
      qneg       <= 1'b0;
      rneg       <= 1'b0;
      zskip      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state  <= state_nxt;
      busy_q <= (state_nxt inside {S_ITER, S_FIXQ, S_FIXR});
      done_q <= (state_nxt == S_DONE);

      if (accept) begin
        quo        <= dv_abs;
        rem        <= '0;
        ds         <= ds_abs;
        cnt        <= '0;
        qneg       <= bus.sign & (bus.dividend[31] ^ bus.divisor[31]);
        rneg       <= dv_neg;
        zskip      <= zero_div;
        div_zero_q <= zero_div;
        if (zero_div) begin
          q_q <= '1;
          r_q <= bus.dividend;
        end
      end else begin
        case (state)
          S_ITER: if (!zskip) begin
            rem <= take ? alu_r : shifted;
            quo <= {quo[30:0], take};
            cnt <= cnt + 5'd1;
          end
          S_FIXQ:  q_q <= qneg ? alu_r : quo;
          S_FIXR:  r_q <= rneg ? alu_r : rem;
          default: ;
        endcase
      end
    end
  end
endmodule
